// File: rtl/scan_sel_sequencer.sv
// Round-robin channel select for a 4-to-1 mux with matching active-low one-hot
// display enables, programmable slot length and per-slot leading blanking.
module scan_sel_sequencer #(
   parameter int CLK_DIV = 50000,
   parameter int BLANK   = 4
) (
   input  logic       i_Clk,
   input  logic       i_Rst_n,
   input  logic       i_Enable,
   input  logic [3:0] i_Mask,
   output logic [1:0] o_Sel,
   output logic [3:0] o_Anodo,
   output logic       o_Blank,
   output logic       o_Tick
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST  = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);

   typedef enum logic [1:0] {
      S_IDLE,
      S_BLANK,
      S_ON
   } state_t;

   // Every new slot starts blanked unless blanking is disabled.
   localparam state_t SLOT_START = (BLANK == 0) ? S_ON : S_BLANK;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    sel_q, sel_d;
   logic [3:0]    anodo_q, anodo_d;
   logic          blank_q, blank_d;
   logic          tick_q, tick_d;
   logic          mask_any;

   // First channel enabled in mask, searching upward from start (inclusive) with wrap.
   function automatic logic [1:0] first_unmasked(input logic [1:0] start,
                                                 input logic [3:0] mask);
      logic [1:0] idx;
      logic       found;
      first_unmasked = start;
      found          = 1'b0;
      for (int i = 0; i < 4; i++) begin
         idx = start + 2'(i);
         if (!found && mask[idx]) begin
            first_unmasked = idx;
            found          = 1'b1;
         end
      end
   endfunction

   assign mask_any = |i_Mask;

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      tick_d  = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (i_Enable && mask_any) begin
               sel_d   = first_unmasked(sel_q, i_Mask);
               state_d = SLOT_START;
               tick_d  = 1'b1;
            end
         end
         default: begin
            // Losing enable or the whole mask beats a coincident slot end.
            if (!i_Enable || !mask_any) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               sel_d   = first_unmasked(sel_q + 2'd1, i_Mask);
               state_d = SLOT_START;
               tick_d  = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (state_q == S_BLANK && cnt_d == CNT_BLANK) begin
                  state_d = S_ON;
               end
            end
         end
      endcase

      // Outputs are built from the next state so they register in step with it;
      // a channel masked mid-slot drops its anode on the very next edge.
      anodo_d = 4'b1111;
      if (state_d == S_ON && i_Mask[sel_d]) begin
         anodo_d[sel_d] = 1'b0;
      end
      blank_d = &anodo_d;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= 2'b00;
         anodo_q <= 4'b1111;
         blank_q <= 1'b1;
         tick_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         anodo_q <= anodo_d;
         blank_q <= blank_d;
         tick_q  <= tick_d;
      end
   end

   assign o_Sel   = sel_q;
   assign o_Anodo = anodo_q;
   assign o_Blank = blank_q;
   assign o_Tick  = tick_q;

endmodule

// File: tb/tb_scan_sel_sequencer.sv
// Directed bench for scan_sel_sequencer: one build with CLK_DIV=8/BLANK=2 and
// one with BLANK=0, driven from the same inputs.
module tb_scan_sel_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [3:0] mask = 4'h0;

   logic [1:0] sel0, sel1;
   logic [3:0] an0, an1;
   logic       bl0, bl1, tk0, tk1;
   logic [7:0] obs0, obs1;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   scan_sel_sequencer #(.CLK_DIV(8), .BLANK(2)) dut (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en), .i_Mask(mask),
      .o_Sel(sel0), .o_Anodo(an0), .o_Blank(bl0), .o_Tick(tk0)
   );

   scan_sel_sequencer #(.CLK_DIV(8), .BLANK(0)) dut_nb (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en), .i_Mask(mask),
      .o_Sel(sel1), .o_Anodo(an1), .o_Blank(bl1), .o_Tick(tk1)
   );

   // Observed word: {sel, anodo, blank, tick}
   assign obs0 = {sel0, an0, bl0, tk0};
   assign obs1 = {sel1, an1, bl1, tk1};

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect0(input string name, input logic [7:0] exp);
      vectors++;
      if (obs0 !== exp) begin
         miscompares++;
         $display("FAIL %s: got sel/anodo/blank/tick=%b required %b", name, obs0, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      mask  = 4'h0;
      step();
      step();
      expect0("reset_state", 8'b00_1111_1_0);
      vectors++;
      if (obs1 !== 8'b00_1111_1_0) begin
         miscompares++;
         $display("FAIL reset_state_nb: got %b required %b", obs1, 8'b00_1111_1_0);
      end
      #2 rst_n = 1'b1;
      step();
      step();
      expect0("idle_after_release", 8'b00_1111_1_0);
   endtask

   // Run n slots from IDLE exit; seq holds the expected select for slot s%4 in seq[2*(s%4)+:2].
   task automatic run_slots(input string name, input int n, input logic [7:0] seq,
                            input bit check_nb);
      logic [1:0] es;
      logic [7:0] exp;
      logic [7:0] exp_nb;
      for (int s = 0; s < n; s++) begin
         for (int k = 0; k < 8; k++) begin
            step();
            es     = seq[2*(s%4) +: 2];
            exp    = {es, (k < 2) ? 4'hF : ~(4'b0001 << es), 1'(k < 2), 1'(k == 0)};
            exp_nb = {es, ~(4'b0001 << es), 1'b0, 1'(k == 0)};
            vectors++;
            if (obs0 !== exp) begin
               miscompares++;
               $display("FAIL %s slot %0d cycle %0d: got %b required %b", name, s, k, obs0, exp);
            end
            if (check_nb) begin
               vectors++;
               if (obs1 !== exp_nb) begin
                  miscompares++;
                  $display("FAIL %s_nb slot %0d cycle %0d: got %b required %b",
                           name, s, k, obs1, exp_nb);
               end
            end
         end
      end
   endtask

   // Drops enable at the last slot cycle: IDLE, select held, no tick.
   task automatic go_idle(input string name, input logic [1:0] held);
      en = 1'b0;
      step();
      expect0(name, {held, 4'hF, 1'b1, 1'b0});
   endtask

   task automatic test_full_scan();
      mask = 4'hF;
      en   = 1'b1;
      run_slots("full_scan", 5, {2'd3, 2'd2, 2'd1, 2'd0}, 1'b1);
      go_idle("full_scan_idle", 2'd0);
      vectors++;
      if (obs1 !== 8'b00_1111_1_0) begin
         miscompares++;
         $display("FAIL full_scan_idle_nb: got %b required %b", obs1, 8'b00_1111_1_0);
      end
   endtask

   task automatic test_masked_skip();
      mask = 4'b1010;
      en   = 1'b1;
      run_slots("masked_skip", 4, {2'd3, 2'd1, 2'd3, 2'd1}, 1'b0);
      go_idle("masked_skip_idle", 2'd3);
   endtask

   task automatic test_single_channel();
      mask = 4'b0100;
      en   = 1'b1;
      run_slots("single_channel", 3, {2'd2, 2'd2, 2'd2, 2'd2}, 1'b0);
      go_idle("single_channel_idle", 2'd2);
   endtask

   task automatic test_mask_edges();
      // Start on channel 1 (searched from held select 2), then open the mask.
      mask = 4'b0010;
      en   = 1'b1;
      step();
      expect0("edge_exit_ch1", 8'b01_1111_1_1);
      mask = 4'hF;
      step();
      step();
      expect0("edge_ch1_on", 8'b01_1101_0_0);
      step();
      step();
      expect0("edge_ch1_cnt4", 8'b01_1101_0_0);
      mask = 4'b1101;
      step();
      expect0("edge_ch1_masked", 8'b01_1111_1_0);
      step();
      step();
      expect0("edge_ch1_masked_end", 8'b01_1111_1_0);
      step();
      expect0("edge_adv_ch2", 8'b10_1111_1_1);
      step();
      step();
      expect0("edge_ch2_on", 8'b10_1011_0_0);
      mask = 4'h0;
      step();
      expect0("edge_mask_zero_idle", 8'b10_1111_1_0);
      step();
      expect0("edge_mask_zero_hold", 8'b10_1111_1_0);
      mask = 4'hF;
      step();
      expect0("edge_reexit_ch2", 8'b10_1111_1_1);
      repeat (7) step();
      expect0("edge_cnt7", 8'b10_1011_0_0);
      en = 1'b0;
      step();
      expect0("edge_enable_drop_at_end", 8'b10_1111_1_0);
      step();
      expect0("edge_idle_hold", 8'b10_1111_1_0);
   endtask

   task automatic test_reset_mid_scan();
      mask = 4'hF;
      en   = 1'b1;
      step();
      expect0("rst_scan_exit", 8'b10_1111_1_1);
      repeat (3) step();
      expect0("rst_scan_ch2_on", 8'b10_1011_0_0);
      #2 rst_n = 1'b0;
      #1;
      expect0("rst_async", 8'b00_1111_1_0);
      vectors++;
      if (obs1 !== 8'b00_1111_1_0) begin
         miscompares++;
         $display("FAIL rst_async_nb: got %b required %b", obs1, 8'b00_1111_1_0);
      end
      en = 1'b0;
      #3 rst_n = 1'b1;
      step();
      step();
      expect0("rst_idle_after_release", 8'b00_1111_1_0);
   endtask

   initial begin
      test_reset();
      test_full_scan();
      test_masked_skip();
      test_single_channel();
      test_mask_edges();
      test_reset_mid_scan();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/scan_sel_sequencer.md
Name: scan_sel_sequencer

Overview:
- Upstream control stage for the team's 4-to-1 data multiplexer. Generates the 2-bit select that picks one of four n-bit data channels, in round-robin order, at a programmable slot rate.
- Also drives matching active-low one-hot channel enables for a 4-digit multiplexed display. Inserts a blanking interval at the start of each slot to suppress ghosting.
- Channels can be skipped through a mask.

Parameters:
- CLK_DIV, 50000, clock cycles per channel slot; must be >= 2.
- BLANK, 4, blanked cycles at the start of each slot; must be < CLK_DIV (0 = no blanking).

Ports:
- i_Clk  input  1  system clock, rising edge.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Enable  input  1  scan run enable.
- i_Mask  input  4  channel enable mask; bit k=1 means channel k is scanned.
- o_Sel  output  2  select to the 4-to-1 mux (i_sel).
- o_Anodo  output  4  one-hot active-low channel enable; 4'b1111 = all off.
- o_Blank  output  1  high while no channel is driven.
- o_Tick  output  1  one-cycle pulse in the first cycle of each new slot.

Behaviour:
- All outputs are registered. Reset applies asynchronously on i_Rst_n low and releases on the next i_Clk edge after i_Rst_n rises.
- Reset values: o_Sel=2'b00, o_Anodo=4'b1111, o_Blank=1, o_Tick=0, slot counter=0, state=IDLE.
- Slot counter width is $clog2(CLK_DIV). It counts 0..CLK_DIV-1 and then wraps to 0.
- State IDLE:
  - Counter held at 0; o_Anodo=1111; o_Blank=1; o_Sel holds its value.
  - Leaves IDLE when i_Enable=1 and i_Mask!=0. On that edge: o_Sel loads the first unmasked channel, searching from the current o_Sel inclusive, upward, with wrap. Counter=0, o_Tick=1, state goes to BLANK (or directly to ON if BLANK=0).
- State BLANK:
  - o_Anodo=1111, o_Blank=1.
  - Goes to ON on the edge where the counter reaches BLANK.
- State ON:
  - o_Anodo bit o_Sel is 0, all other bits 1; o_Blank=0.
- Slot end (counter==CLK_DIV-1, in BLANK or ON):
  - Next edge: counter goes to 0 and o_Sel advances to the next unmasked channel, searching sel+1, sel+2, sel+3, sel (mod 4).
  - o_Tick=1 for exactly that cycle; state goes to BLANK (ON if BLANK=0).
  - If only the current channel is unmasked, o_Sel is unchanged, but blanking and o_Tick still occur.
- Timing rules:
  - o_Sel changes only at slot boundaries or on IDLE exit, never mid-slot.
  - o_Sel is always stable for at least BLANK cycles before an anode asserts.
- Mask change mid-slot:
  - If the current channel becomes masked, its anode deasserts on the next edge (o_Blank=1). The slot runs to completion and the next advance uses the new mask.
  - If i_Mask becomes 0, go to IDLE on the next edge.
- i_Enable low in any state: go to IDLE on the next edge. Anodes off from that cycle, o_Tick=0, o_Sel held.
- Simultaneous i_Enable fall and slot end: IDLE wins; o_Sel does not advance and no o_Tick.
- o_Anodo never has more than one bit low in any cycle, including across transitions.

Test Plan:
Bench parameters: CLK_DIV=8, BLANK=2.
- Reset mid-scan: i_Rst_n low asynchronously during ON on channel 2 -> outputs go immediately to o_Sel=00, o_Anodo=1111, o_Blank=1, o_Tick=0; IDLE holds after release while i_Enable=0.
- Full scan: i_Mask=1111, i_Enable=1 from IDLE -> o_Sel sequence 0,1,2,3,0 with 8 cycles per slot. o_Tick pulses every 8th cycle. In each slot, o_Anodo=1111 for 2 cycles, then 1110/1101/1011/0111 for 6 cycles.
- Masked skip: i_Mask=1010 -> o_Sel alternates 1,3,1,3; o_Anodo only ever 1101 or 0111 when active.
- Single channel: i_Mask=0100 -> o_Sel stays at 2. Every 8 cycles: o_Tick=1 and 2 blank cycles, then o_Anodo=1011 for 6 cycles.
- Mask/enable edges:
  - Mask channel 1 at ON cycle 4 of its slot -> o_Anodo=1111 the next cycle, advance to channel 2 on schedule.
  - i_Mask=0000 -> IDLE the next cycle.
  - Drop i_Enable exactly at counter=7 -> IDLE, o_Sel unchanged, no o_Tick.
- BLANK=0 build: full scan -> anode active in every slot cycle, o_Blank never high while enabled, transitions directly one-hot to one-hot.
